// File: rtl/y_bridge_driver.sv
`default_nettype none
// ============================================================================
//  Module      : y_bridge_driver
//  Description : Y-axis H-bridge gate driver. It synchronises the PWM request,
//                direction and over-current inputs. It inserts dead time on
//                every turn-on and turn-off, and latches bridge faults until
//                they are cleared. It also counts drive pulses, saturating
//                at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module y_bridge_driver #(
  parameter int DEAD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             sysclk,
  input  logic             Reset,
  input  logic             Pulse_In,
  input  logic             Dir,
  input  logic             Fault_In,
  input  logic             Clear_Fault,
  output logic             HS_A,
  output logic             LS_A,
  output logic             HS_B,
  output logic             LS_B,
  output logic             Fault_Latched,
  output logic [CNT_W-1:0] Pulse_Count
);

  // Controller states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DEAD_ON  = 3'd1;
  localparam logic [2:0] ST_DRIVE    = 3'd2;
  localparam logic [2:0] ST_DEAD_OFF = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  // The dead counter runs 0 .. DEAD_CYCLES-1. Six bits cover the 1-63 range.
  localparam logic [5:0]       DEAD_LAST = 6'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Two-stage synchronisers for the asynchronous inputs
  logic p_meta_q, p_meta_d, p_s_q, p_s_d;
  logic d_meta_q, d_meta_d, d_s_q, d_s_d;
  logic f_meta_q, f_meta_d, f_s_q, f_s_d;

  // Control state
  logic [2:0]       state_q, state_d;
  logic [5:0]       dead_cnt_q, dead_cnt_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

  // Next-state logic: synchronisers, FSM, dead counter, direction and pulse count
  always_comb begin
    p_meta_d    = Pulse_In;
    p_s_d       = p_meta_q;
    d_meta_d    = Dir;
    d_s_d       = d_meta_q;
    f_meta_d    = Fault_In;
    f_s_d       = f_meta_q;

    state_d     = state_q;
    dead_cnt_d  = dead_cnt_q;
    dir_d       = dir_q;
    pulse_cnt_d = pulse_cnt_q;

    // The count clear is tied to the current IDLE state. It does not depend on
    // the transition taken, so it still happens on the edge that leaves IDLE.
    if ((state_q == ST_IDLE) && Clear_Fault) begin
      pulse_cnt_d = '0;
    end

    if (f_s_q) begin
      // An over-current flag overrides every other transition.
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (p_s_q) begin
            state_d    = ST_DEAD_ON;
            dir_d      = d_s_q;
            dead_cnt_d = '0;
          end
        end

        ST_DEAD_ON: begin
          if (!p_s_q) begin
            // Request withdrawn before the bridge was enabled. Run the full
            // turn-off dead time anyway, so the timing stays simple.
            state_d    = ST_DEAD_OFF;
            dead_cnt_d = '0;
          end else if (dead_cnt_q == DEAD_LAST) begin
            state_d    = ST_DRIVE;
            dead_cnt_d = '0;
            if (pulse_cnt_q != CNT_MAX) begin
              pulse_cnt_d = pulse_cnt_q + CNT_ONE;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + 6'd1;
          end
        end

        ST_DRIVE: begin
          // A direction change never flips diagonals directly. It always
          // goes back through DEAD_OFF and IDLE.
          if (!p_s_q || (d_s_q != dir_q)) begin
            state_d    = ST_DEAD_OFF;
            dead_cnt_d = '0;
          end
        end

        ST_DEAD_OFF: begin
          if (dead_cnt_q == DEAD_LAST) begin
            state_d    = ST_IDLE;
            dead_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q + 6'd1;
          end
        end

        ST_FAULT: begin
          // f_s is known low here, because the fault branch above has priority.
          if (Clear_Fault) begin
            state_d    = ST_IDLE;
            dead_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          dead_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge sysclk) begin
    if (Reset) begin
      p_meta_q    <= 1'b0;
      p_s_q       <= 1'b0;
      d_meta_q    <= 1'b0;
      d_s_q       <= 1'b0;
      f_meta_q    <= 1'b0;
      f_s_q       <= 1'b0;
      state_q     <= ST_IDLE;
      dead_cnt_q  <= '0;
      dir_q       <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      p_meta_q    <= p_meta_d;
      p_s_q       <= p_s_d;
      d_meta_q    <= d_meta_d;
      d_s_q       <= d_s_d;
      f_meta_q    <= f_meta_d;
      f_s_q       <= f_s_d;
      state_q     <= state_d;
      dead_cnt_q  <= dead_cnt_d;
      dir_q       <= dir_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  // Moore output decode. Each diagonal is driven only in DRIVE, so a
  // high side and the low side below it are never on together.
  always_comb begin
    HS_A = 1'b0;
    LS_A = 1'b0;
    HS_B = 1'b0;
    LS_B = 1'b0;
    if (state_q == ST_DRIVE) begin
      if (dir_q) begin
        HS_B = 1'b1;
        LS_A = 1'b1;
      end else begin
        HS_A = 1'b1;
        LS_B = 1'b1;
      end
    end
  end

  assign Fault_Latched = (state_q == ST_FAULT);
  assign Pulse_Count   = pulse_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_y_bridge_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y_bridge_driver
//  Description : Self-checking bench for y_bridge_driver. A phase/countdown
//                reference model is compared against the DUT every cycle.
//                Directed scenarios carry literal expected values, followed
//                by a random soak.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y_bridge_driver;

  localparam int DEAD_CYCLES = 4;
  localparam int CNT_W       = 4;

  logic             sysclk = 1'b0;
  logic             Reset, Pulse_In, Dir, Fault_In, Clear_Fault;
  logic             HS_A, LS_A, HS_B, LS_B, Fault_Latched;
  logic [CNT_W-1:0] Pulse_Count;
  logic [3:0]       g;

  int n_cmp = 0;
  int n_bad = 0;

  assign g = {HS_A, LS_A, HS_B, LS_B};

  always #5 sysclk = ~sysclk;

  y_bridge_driver #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .sysclk        (sysclk),
    .Reset         (Reset),
    .Pulse_In      (Pulse_In),
    .Dir           (Dir),
    .Fault_In      (Fault_In),
    .Clear_Fault   (Clear_Fault),
    .HS_A          (HS_A),
    .LS_A          (LS_A),
    .HS_B          (HS_B),
    .LS_B          (LS_B),
    .Fault_Latched (Fault_Latched),
    .Pulse_Count   (Pulse_Count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each phase has a remaining-cycle budget. Synchronised inputs are kept
  // as two-deep delay lines.
  localparam int M_IDLE = 0, M_DON = 1, M_DRIVE = 2, M_DOFF = 3, M_FAULT = 4;
  int     m_phase = M_IDLE;
  int     m_left  = 0;
  bit     m_dir   = 0;
  longint m_cnt   = 0;
  longint m_max   = (longint'(1) << CNT_W) - 1;
  bit     m_p1 = 0, m_p2 = 0, m_d1 = 0, m_d2 = 0, m_f1 = 0, m_f2 = 0;
  bit     m_valid = 0;

  always @(posedge sysclk) begin
    if (Reset) begin
      m_phase = M_IDLE; m_left = 0; m_dir = 0; m_cnt = 0;
      m_p1 = 0; m_p2 = 0; m_d1 = 0; m_d2 = 0; m_f1 = 0; m_f2 = 0;
      m_valid = 1;
    end else begin
      if (m_phase == M_IDLE && Clear_Fault) m_cnt = 0;
      if (m_f2) begin
        m_phase = M_FAULT;
      end else begin
        case (m_phase)
          M_IDLE:
            if (m_p2) begin m_phase = M_DON; m_left = DEAD_CYCLES; m_dir = m_d2; end
          M_DON:
            if (!m_p2) begin
              m_phase = M_DOFF; m_left = DEAD_CYCLES;
            end else if (m_left == 1) begin
              m_phase = M_DRIVE;
              if (m_cnt < m_max) m_cnt = m_cnt + 1;
            end else begin
              m_left = m_left - 1;
            end
          M_DRIVE:
            if (!m_p2 || (m_d2 != m_dir)) begin m_phase = M_DOFF; m_left = DEAD_CYCLES; end
          M_DOFF:
            if (m_left == 1) m_phase = M_IDLE; else m_left = m_left - 1;
          default:
            if (Clear_Fault) m_phase = M_IDLE;
        endcase
      end
      m_p2 = m_p1; m_p1 = Pulse_In;
      m_d2 = m_d1; m_d1 = Dir;
      m_f2 = m_f1; m_f1 = Fault_In;
    end
  end

  // Every-cycle compare against the model, plus safety invariants
  int         offrun = 0;
  logic [3:0] prev_g = 4'b0000;
  logic [3:0] exp_g;

  always @(negedge sysclk) begin
    if (m_valid) begin
      exp_g = (m_phase == M_DRIVE) ? (m_dir ? 4'b0110 : 4'b1001) : 4'b0000;
      chk("model_gates", {28'd0, g}, {28'd0, exp_g});
      chk("model_fault", {31'd0, Fault_Latched}, {31'd0, (m_phase == M_FAULT)});
      chk("model_count", {{(32-CNT_W){1'b0}}, Pulse_Count}, 32'(m_cnt));
      chk("shoot_through", {31'd0, (HS_A & LS_A) | (HS_B & LS_B)}, 32'd0);
      if (g != 4'b0000 && prev_g == 4'b0000)
        chk("dead_time_before_drive", {31'd0, offrun >= DEAD_CYCLES}, 32'd1);
      if (g == 4'b0000) offrun++; else offrun = 0;
      prev_g = g;
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    Reset = 1'b1; Pulse_In = 1'b0; Dir = 1'b0; Fault_In = 1'b0; Clear_Fault = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("reset_gates", {28'd0, g}, 32'd0);
    chk("reset_fault", {31'd0, Fault_Latched}, 32'd0);
    chk("reset_count", {28'd0, Pulse_Count}, 32'd0);
    Reset = 1'b0;
    @(negedge sysclk);

    // Forward request: 2 sync + 4 dead-on cycles all off, then forward diagonal
    Pulse_In = 1'b1; Dir = 1'b0;
    repeat (6) begin @(negedge sysclk); chk("fwd_off", {28'd0, g}, 32'd0); end
    @(negedge sysclk);
    chk("fwd_drive", {28'd0, g}, 32'b1001);
    chk("fwd_count", {28'd0, Pulse_Count}, 32'd1);

    // Reverse while driving: 2 sync, 4 dead-off, 1 idle, 4 dead-on, then reverse diagonal
    Dir = 1'b1;
    repeat (2) begin @(negedge sysclk); chk("rev_hold", {28'd0, g}, 32'b1001); end
    repeat (9) begin @(negedge sysclk); chk("rev_off", {28'd0, g}, 32'd0); end
    @(negedge sysclk);
    chk("rev_drive", {28'd0, g}, 32'b0110);
    chk("rev_count", {28'd0, Pulse_Count}, 32'd2);

    // Short request aborts during dead-on
    Pulse_In = 1'b0;
    repeat (12) @(negedge sysclk);
    Pulse_In = 1'b1;
    repeat (3) @(negedge sysclk);
    Pulse_In = 1'b0;
    repeat (15) begin @(negedge sysclk); chk("abort_off", {28'd0, g}, 32'd0); end
    chk("abort_count", {28'd0, Pulse_Count}, 32'd2);

    // Fault while driving; clear is refused while the flag is still high
    Pulse_In = 1'b1;
    repeat (7) @(negedge sysclk);
    chk("pre_fault_drive", {28'd0, g}, 32'b0110);
    Fault_In = 1'b1;
    repeat (2) begin @(negedge sysclk); chk("fault_sync_hold", {28'd0, g}, 32'b0110); end
    @(negedge sysclk);
    chk("fault_latched", {31'd0, Fault_Latched}, 32'd1);
    chk("fault_gates", {28'd0, g}, 32'd0);
    chk("fault_count", {28'd0, Pulse_Count}, 32'd3);
    Clear_Fault = 1'b1;
    repeat (5) begin @(negedge sysclk); chk("fault_stuck", {31'd0, Fault_Latched}, 32'd1); end
    Fault_In = 1'b0; Pulse_In = 1'b0;
    repeat (2) begin @(negedge sysclk); chk("fault_clear_wait", {31'd0, Fault_Latched}, 32'd1); end
    @(negedge sysclk);
    chk("fault_cleared", {31'd0, Fault_Latched}, 32'd0);
    @(negedge sysclk);
    chk("idle_clear_count", {28'd0, Pulse_Count}, 32'd0);
    Clear_Fault = 1'b0;

    // 2^CNT_W+2 pulses: the count saturates at all-ones
    repeat ((1 << CNT_W) + 2) begin
      Pulse_In = 1'b1; repeat (8) @(negedge sysclk);
      Pulse_In = 1'b0; repeat (8) @(negedge sysclk);
    end
    chk("count_saturated", {28'd0, Pulse_Count}, 32'd15);

    // Reset during DRIVE drops the gates on the same edge
    Pulse_In = 1'b1;
    repeat (7) @(negedge sysclk);
    chk("pre_reset_drive", {28'd0, g}, 32'b0110);
    Reset = 1'b1;
    @(negedge sysclk);
    chk("reset_in_drive_gates", {28'd0, g}, 32'd0);
    chk("reset_in_drive_count", {28'd0, Pulse_Count}, 32'd0);
    Reset = 1'b0; Pulse_In = 1'b0;
    repeat (4) @(negedge sysclk);

    // Random soak
    repeat (4000) begin
      @(negedge sysclk);
      if ($urandom_range(0, 19) == 0) Pulse_In = ~Pulse_In;
      if ($urandom_range(0, 59) == 0) Dir = ~Dir;
      Fault_In    = ($urandom_range(0, 399) == 0);
      Clear_Fault = ($urandom_range(0, 9) == 0);
    end
    repeat (3) @(negedge sysclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
